// File: rtl/cfi_mailbox.sv
// Register-mapped mailbox between a CFI log producer and a Root-of-Trust consumer.
// Owns the doorbell/completion handshake, overrun tracking and a completed-handshake counter.
module cfi_mailbox #(
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(32'h1040_4000),
    parameter int unsigned           NR_DATA_WORDS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // Producer (CFI log path)
    input  logic                  prod_req_i,
    input  logic                  prod_we_i,
    input  logic [ADDR_WIDTH-1:0] prod_addr_i,
    input  logic [31:0]           prod_wdata_i,
    output logic                  prod_gnt_o,
    output logic                  prod_rvalid_o,
    output logic [31:0]           prod_rdata_o,
    output logic                  prod_err_o,
    // Consumer (RoT checker)
    input  logic                  cons_req_i,
    input  logic                  cons_we_i,
    input  logic [ADDR_WIDTH-1:0] cons_addr_i,
    input  logic [31:0]           cons_wdata_i,
    output logic                  cons_gnt_o,
    output logic                  cons_rvalid_o,
    output logic [31:0]           cons_rdata_o,
    output logic                  cons_err_o,
    // Interrupts / status
    output logic                  doorbell_irq_o,
    output logic                  completion_irq_o,
    output logic                  busy_o
);

    localparam int unsigned IdxW = (NR_DATA_WORDS > 1) ? $clog2(NR_DATA_WORDS) : 1;
    localparam int unsigned WordW = ADDR_WIDTH - 2;
    localparam logic [WordW-1:0] DbWord  = WordW'(NR_DATA_WORDS);
    localparam logic [WordW-1:0] CmpWord = WordW'(NR_DATA_WORDS + 1);
    localparam logic [WordW-1:0] StsWord = WordW'(NR_DATA_WORDS + 2);
    localparam logic [ADDR_WIDTH-1:0] LastOff = ADDR_WIDTH'(4 * NR_DATA_WORDS + 8);

    typedef enum logic {StIdle, StPending} state_e;

    typedef struct packed {
        logic            ok;
        logic            data;
        logic            db;
        logic            cmp;
        logic            sts;
        logic [IdxW-1:0] idx;
    } dec_t;

    state_e      state_q, state_d;
    logic [31:0] data_q [NR_DATA_WORDS];
    logic [31:0] data_d [NR_DATA_WORDS];
    logic [31:0] cmp_q, cmp_d;
    logic        ovr_q, ovr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cirq_q, cirq_d;
    logic        p_rvalid_q, p_rvalid_d, p_err_q, p_err_d;
    logic        c_rvalid_q, c_rvalid_d, c_err_q, c_err_d;
    logic [31:0] p_rdata_q, p_rdata_d, c_rdata_q, c_rdata_d;
    logic        pending;
    logic        ovr_set, ovr_clr;
    dec_t        p_dec, c_dec;

    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        logic [WordW-1:0]      w;
        decode = '0;
        off    = addr - BASE_ADDR;
        w      = off[ADDR_WIDTH-1:2];
        if (addr >= BASE_ADDR && off <= LastOff && addr[1:0] == 2'b00) begin
            decode.ok   = 1'b1;
            decode.data = (w < DbWord);
            decode.db   = (w == DbWord);
            decode.cmp  = (w == CmpWord);
            decode.sts  = (w == StsWord);
            decode.idx  = w[IdxW-1:0];
        end
    endfunction

    // Reads observe pre-edge state, so same-cycle writes are never visible.
    function automatic logic [31:0] read_reg(input dec_t d);
        read_reg = '0;
        if (d.data) read_reg = data_q[d.idx];
        if (d.db)   read_reg = {31'b0, pending};
        if (d.cmp)  read_reg = cmp_q;
        if (d.sts)  read_reg = {cnt_q, 14'b0, ovr_q, pending};
    endfunction

    assign pending = (state_q == StPending);

    always_comb begin
        p_dec = decode(prod_addr_i);
        c_dec = decode(cons_addr_i);
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cmp_d      = cmp_q;
        cnt_d      = cnt_q;
        cirq_d     = 1'b0;
        ovr_set    = 1'b0;
        ovr_clr    = 1'b0;
        p_rvalid_d = prod_req_i;
        p_err_d    = 1'b0;
        p_rdata_d  = '0;
        c_rvalid_d = cons_req_i;
        c_err_d    = 1'b0;
        c_rdata_d  = '0;

        // Producer side decisions use the current state only.
        if (prod_req_i) begin
            if (!p_dec.ok) begin
                p_err_d = 1'b1;
            end else if (prod_we_i) begin
                if (p_dec.data || p_dec.db) begin
                    if (pending) begin
                        p_err_d = 1'b1;
                        ovr_set = 1'b1;
                    end else if (p_dec.data) begin
                        data_d[p_dec.idx] = prod_wdata_i;
                    end else begin
                        state_d = StPending;
                    end
                end else begin
                    p_err_d = 1'b1;
                end
            end else begin
                p_rdata_d = read_reg(p_dec);
            end
        end

        if (cons_req_i) begin
            if (!c_dec.ok) begin
                c_err_d = 1'b1;
            end else if (cons_we_i) begin
                if (c_dec.cmp) begin
                    if (pending) begin
                        cmp_d   = cons_wdata_i;
                        state_d = StIdle;
                        cirq_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        c_err_d = 1'b1;
                    end
                end else if (c_dec.sts) begin
                    ovr_clr = cons_wdata_i[1];
                end else begin
                    c_err_d = 1'b1;
                end
            end else begin
                c_rdata_d = read_reg(c_dec);
            end
        end

        ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            for (int i = 0; i < NR_DATA_WORDS; i++) data_q[i] <= '0;
            cmp_q      <= '0;
            ovr_q      <= 1'b0;
            cnt_q      <= '0;
            cirq_q     <= 1'b0;
            p_rvalid_q <= 1'b0;
            p_err_q    <= 1'b0;
            p_rdata_q  <= '0;
            c_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            c_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cmp_q      <= cmp_d;
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
            cirq_q     <= cirq_d;
            p_rvalid_q <= p_rvalid_d;
            p_err_q    <= p_err_d;
            p_rdata_q  <= p_rdata_d;
            c_rvalid_q <= c_rvalid_d;
            c_err_q    <= c_err_d;
            c_rdata_q  <= c_rdata_d;
        end
    end

    assign prod_gnt_o       = prod_req_i;
    assign prod_rvalid_o    = p_rvalid_q;
    assign prod_rdata_o     = p_rdata_q;
    assign prod_err_o       = p_err_q;
    assign cons_gnt_o       = cons_req_i;
    assign cons_rvalid_o    = c_rvalid_q;
    assign cons_rdata_o     = c_rdata_q;
    assign cons_err_o       = c_err_q;
    assign doorbell_irq_o   = pending;
    assign busy_o           = pending;
    assign completion_irq_o = cirq_q;

endmodule

// File: tb/tb_cfi_mailbox.sv
// Scoreboard bench for cfi_mailbox: stimulus queues expected responses, a monitor
// pops them whenever a port presents rvalid.
module tb_cfi_mailbox;

    localparam logic [31:0] Base = 32'h1040_4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prod_req_i = 0, prod_we_i = 0;
    logic [31:0] prod_addr_i = 0, prod_wdata_i = 0;
    logic        cons_req_i = 0, cons_we_i = 0;
    logic [31:0] cons_addr_i = 0, cons_wdata_i = 0;
    logic        prod_gnt_o, prod_rvalid_o, prod_err_o;
    logic [31:0] prod_rdata_o;
    logic        cons_gnt_o, cons_rvalid_o, cons_err_o;
    logic [31:0] cons_rdata_o;
    logic        doorbell_irq_o, completion_irq_o, busy_o;

    always #5 clk = ~clk;

    cfi_mailbox #(
        .ADDR_WIDTH   (32),
        .BASE_ADDR    (Base),
        .NR_DATA_WORDS(8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .prod_req_i      (prod_req_i),
        .prod_we_i       (prod_we_i),
        .prod_addr_i     (prod_addr_i),
        .prod_wdata_i    (prod_wdata_i),
        .prod_gnt_o      (prod_gnt_o),
        .prod_rvalid_o   (prod_rvalid_o),
        .prod_rdata_o    (prod_rdata_o),
        .prod_err_o      (prod_err_o),
        .cons_req_i      (cons_req_i),
        .cons_we_i       (cons_we_i),
        .cons_addr_i     (cons_addr_i),
        .cons_wdata_i    (cons_wdata_i),
        .cons_gnt_o      (cons_gnt_o),
        .cons_rvalid_o   (cons_rvalid_o),
        .cons_rdata_o    (cons_rdata_o),
        .cons_err_o      (cons_err_o),
        .doorbell_irq_o  (doorbell_irq_o),
        .completion_irq_o(completion_irq_o),
        .busy_o          (busy_o)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t p_q[$];
    exp_t c_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        exp_t pe, ce;
        forever begin
            @(posedge clk);
            #1;
            if (prod_rvalid_o) begin
                if (p_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL prod_unexpected_rvalid: got rvalid=1 expected none");
                end else begin
                    pe = p_q.pop_front();
                    chk("prod_rdata", prod_rdata_o, pe.rd);
                    chk("prod_err", {31'b0, prod_err_o}, {31'b0, pe.err});
                end
            end
            if (cons_rvalid_o) begin
                if (c_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cons_unexpected_rvalid: got rvalid=1 expected none");
                end else begin
                    ce = c_q.pop_front();
                    chk("cons_rdata", cons_rdata_o, ce.rd);
                    chk("cons_err", {31'b0, cons_err_o}, {31'b0, ce.err});
                end
            end
        end
    end

    task automatic drive(input logic pr, input logic pw, input logic [31:0] po,
                         input logic [31:0] pwd, input logic [31:0] prd, input logic pe,
                         input logic cr, input logic cw, input logic [31:0] co,
                         input logic [31:0] cwd, input logic [31:0] crd, input logic ce);
        @(negedge clk);
        prod_req_i   = pr;
        prod_we_i    = pw;
        prod_addr_i  = Base + po;
        prod_wdata_i = pwd;
        cons_req_i   = cr;
        cons_we_i    = cw;
        cons_addr_i  = Base + co;
        cons_wdata_i = cwd;
        if (pr) p_q.push_back('{rd: prd, err: pe});
        if (cr) c_q.push_back('{rd: crd, err: ce});
    endtask

    task automatic idle();
        @(negedge clk);
        prod_req_i = 1'b0;
        prod_we_i  = 1'b0;
        cons_req_i = 1'b0;
        cons_we_i  = 1'b0;
    endtask

    task automatic pacc(input logic we, input logic [31:0] off, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err);
        drive(1'b1, we, off, wd, rd, err, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();
    endtask

    task automatic cacc(input logic we, input logic [31:0] off, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, we, off, wd, rd, err);
        idle();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_doorbell_irq", {31'b0, doorbell_irq_o}, 32'h0);
        chk("rst_completion_irq", {31'b0, completion_irq_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_rvalid", {30'b0, prod_rvalid_o, cons_rvalid_o}, 32'h0);
        chk("rst_rdata_or", prod_rdata_o | cons_rdata_o, 32'h0);
        chk("rst_err", {30'b0, prod_err_o, cons_err_o}, 32'h0);
        rst = 1'b0;

        // Basic handshake
        for (int i = 0; i < 8; i++) pacc(1'b1, 32'(4 * i), 32'(32'hA0 + i), 32'h0, 1'b0);
        pacc(1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        chk("db_irq_rise", {31'b0, doorbell_irq_o}, 32'h1);
        chk("busy_pending", {31'b0, busy_o}, 32'h1);
        cacc(1'b0, 32'h1C, 32'h0, 32'hA7, 1'b0);
        cacc(1'b0, 32'h20, 32'h0, 32'h1, 1'b0);
        pacc(1'b0, 32'h28, 32'h0, 32'h1, 1'b0);
        cacc(1'b1, 32'h24, 32'h5, 32'h0, 1'b0);
        chk("cmp_irq_pulse", {31'b0, completion_irq_o}, 32'h1);
        chk("db_irq_fall", {31'b0, doorbell_irq_o}, 32'h0);
        @(negedge clk);
        chk("cmp_irq_one_cycle", {31'b0, completion_irq_o}, 32'h0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0001_0000, 1'b0);
        pacc(1'b0, 32'h24, 32'h0, 32'h5, 1'b0);

        // Overrun
        pacc(1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        pacc(1'b1, 32'h00, 32'h11, 32'h0, 1'b1);
        pacc(1'b0, 32'h00, 32'h0, 32'hA0, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0001_0003, 1'b0);
        cacc(1'b1, 32'h28, 32'h2, 32'h0, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0001_0001, 1'b0);
        cacc(1'b1, 32'h24, 32'h6, 32'h0, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0002_0000, 1'b0);

        // Illegal accesses
        cacc(1'b1, 32'h24, 32'h9, 32'h0, 1'b1);
        pacc(1'b0, 32'h24, 32'h0, 32'h6, 1'b0);
        pacc(1'b1, 32'h28, 32'hFFFF_FFFF, 32'h0, 1'b1);
        cacc(1'b0, 32'h28, 32'h0, 32'h0002_0000, 1'b0);
        pacc(1'b0, 32'h2C, 32'h0, 32'h0, 1'b1);
        pacc(1'b1, 32'h2C, 32'h5, 32'h0, 1'b1);
        pacc(1'b1, 32'h02, 32'h33, 32'h0, 1'b1);
        pacc(1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
        cacc(1'b0, 32'h00, 32'h0, 32'hA0, 1'b0);
        cacc(1'b1, 32'h04, 32'h44, 32'h0, 1'b1);
        cacc(1'b1, 32'h20, 32'h1, 32'h0, 1'b1);
        chk("cons_db_ignored", {31'b0, doorbell_irq_o}, 32'h0);
        pacc(1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        pacc(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
        pacc(1'b0, 32'h04, 32'h0, 32'hA1, 1'b0);

        // Same-cycle doorbell and completion from IDLE
        drive(1'b1, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h24, 32'h7, 32'h0, 1'b1);
        idle();
        chk("sim_idle_db_irq", {31'b0, doorbell_irq_o}, 32'h1);
        chk("sim_idle_no_cmp_irq", {31'b0, completion_irq_o}, 32'h0);
        pacc(1'b0, 32'h24, 32'h0, 32'h6, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0002_0001, 1'b0);

        // Same-cycle events from PENDING
        drive(1'b1, 1'b1, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h24, 32'h8, 32'h0, 1'b0);
        idle();
        chk("sim_pend_cmp_irq", {31'b0, completion_irq_o}, 32'h1);
        chk("sim_pend_db_irq", {31'b0, doorbell_irq_o}, 32'h0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0003_0002, 1'b0);
        pacc(1'b0, 32'h24, 32'h0, 32'h8, 1'b0);

        // Overrun set beats same-cycle clear
        cacc(1'b1, 32'h28, 32'h2, 32'h0, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0003_0000, 1'b0);
        pacc(1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h00, 32'h55, 32'h0, 1'b1, 1'b1, 1'b1, 32'h28, 32'h2, 32'h0, 1'b0);
        idle();
        cacc(1'b0, 32'h28, 32'h0, 32'h0003_0003, 1'b0);
        cacc(1'b1, 32'h24, 32'h0, 32'h0, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0004_0002, 1'b0);
        cacc(1'b1, 32'h28, 32'h2, 32'h0, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0004_0000, 1'b0);

        // Counter wrap: four handshakes done, 65532 more reach 65536
        for (int i = 0; i < 65532; i++) begin
            drive(1'b1, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h24, 32'(i), 32'h0, 1'b0);
        end
        idle();
        cacc(1'b0, 32'h28, 32'h0, 32'h0000_0000, 1'b0);
        pacc(1'b0, 32'h24, 32'h0, 32'h0000_FFFB, 1'b0);

        // Asynchronous reset while PENDING
        pacc(1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        chk("pre_rst_db_irq", {31'b0, doorbell_irq_o}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_db_irq", {31'b0, doorbell_irq_o}, 32'h0);
        chk("async_rst_busy", {31'b0, busy_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) pacc(1'b0, 32'(4 * i), 32'h0, 32'h0, 1'b0);
        cacc(1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        cacc(1'b0, 32'h24, 32'h0, 32'h0, 1'b0);
        cacc(1'b0, 32'h28, 32'h0, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk("prod_queue_drained", 32'(p_q.size()), 32'h0);
        chk("cons_queue_drained", 32'(c_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfi_mailbox.md
# cfi_mailbox

- Register-mapped mailbox between the CVA6 CFI log path (producer) and the Root-of-Trust checker (consumer).
- The producer writes log words and rings a doorbell. The mailbox raises a level interrupt to the consumer, which reads the words and writes a completion code.
- The mailbox then pulses `completion_irq_o`, which drives the core's `mbox_completion_irq_i`.
- Both sides use single-cycle register ports; the block owns the handshake state and status bookkeeping.

## Interface
- `BASE_ADDR`, default 'h10404000: mailbox base; all offsets are relative to it.
- `ADDR_WIDTH`, default 32: address width of both ports.
- `NR_DATA_WORDS`, default 8: number of 32-bit data words. They sit at offsets 0 to 4·(N-1). DOORBELL is at 4·N, COMPLETION at 4·N+4, STATUS at 4·N+8. With N=8: 0x20, 0x24, 0x28.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `prod_req_i`, `prod_we_i`, in, 1 each: producer request and write-enable.
- `prod_addr_i`, in, ADDR_WIDTH: producer byte address.
- `prod_wdata_i`, in, 32: producer write data.
- `prod_gnt_o`, out, 1: producer grant.
- `prod_rvalid_o`, out, 1: producer response valid.
- `prod_rdata_o`, out, 32: producer read data.
- `prod_err_o`, out, 1: producer error response.
- `cons_*`: same eight signals for the consumer (RoT) port.
- `doorbell_irq_o`, out, 1: level interrupt to the consumer, high while PENDING.
- `completion_irq_o`, out, 1: one-cycle pulse to the core.
- `busy_o`, out, 1: equals PENDING.

## Operation
- States:
  - IDLE is the reset state.
  - IDLE -> PENDING on an accepted producer write to DOORBELL.
  - PENDING -> IDLE on an accepted consumer write to COMPLETION.
- Data words:
  - Producer write in IDLE updates the word.
  - Producer write to data or DOORBELL in PENDING is ignored; it sets the sticky STATUS[1] overrun bit and returns err=1.
  - Consumer writes to data words or DOORBELL return err=1 and are ignored.
  - Both ports may read data words in any state.
- COMPLETION:
  - Consumer write in PENDING stores wdata, leaves PENDING and schedules the completion pulse.
  - Consumer write in IDLE returns err=1 and is ignored.
  - Producer write returns err=1.
  - Both ports may read it.
- STATUS:
  - Bit 0 is pending.
  - Bit 1 is overrun (sticky).
  - Bits [31:16] hold the completed-handshake count: 16 bits, increments on each completion, wraps 0xFFFF -> 0.
  - Bits [15:2] read as 0.
  - A consumer write with wdata[1]=1 clears overrun. Other STATUS write bits are ignored.
  - A producer write to STATUS returns err=1.
- DOORBELL reads return {31'b0, pending}.
- Decode errors: address outside [BASE, BASE+4·N+8] or addr[1:0]≠0 gives err=1, rdata=0, no state change.
- Simultaneous events in one cycle:
  - Producer doorbell in IDLE together with consumer completion: completion errors, because state is still IDLE; next state is PENDING.
  - Consumer completion in PENDING together with producer doorbell: producer gets the overrun error, because state is still PENDING; next state is IDLE and overrun is set.
  - Overrun set and consumer clear in the same cycle: set wins.
- Reset mid-handshake: state returns to IDLE and irqs drop immediately (asynchronous).

## Timing
- Grant: `*_gnt_o` = `*_req_i` combinationally; there is no back-pressure.
- Writes commit on the clock edge where req & gnt.
- Response: `*_rvalid_o` goes high exactly one cycle after acceptance, with registered `rdata`/`err`. For writes, rdata=0.
- Read timing: a read returns state as of the acceptance edge, before that cycle's writes.
- `doorbell_irq_o` rises the cycle after the doorbell edge and falls the cycle after the completion edge.
- `completion_irq_o` is registered: high for exactly one cycle, the cycle after the completion write is accepted.
- Reset values:
  - State IDLE.
  - All data words, COMPLETION and the counter are 0; overrun is 0.
  - All outputs are 0, including rvalid, err, rdata and both irqs.

## Test plan
- Basic handshake:
  - Stimulus: producer writes 0xA0..0xA7 to offsets 0x00–0x1C, then writes DOORBELL.
  - Response: `doorbell_irq_o`=1 the next cycle; consumer reads 0x1C -> 0xA7.
  - Stimulus: consumer writes COMPLETION=0x5.
  - Response: one-cycle `completion_irq_o`; STATUS reads 0x0001_0000; producer reads COMPLETION -> 0x5.
- Overrun:
  - Stimulus: producer writes word 0 = 0x11 while PENDING.
  - Response: err=1; word 0 is unchanged; STATUS[1]=1.
  - Stimulus: consumer writes STATUS=0x2.
  - Response: STATUS[1]=0.
- Illegal accesses each give err=1, rvalid one cycle later and no state change:
  - Consumer COMPLETION write in IDLE.
  - Producer STATUS write.
  - Address BASE+0x2C.
  - Address BASE+0x02.
- Simultaneous events:
  - Same-cycle doorbell and completion from IDLE -> completion errors, state PENDING.
  - Same-cycle events from PENDING -> state IDLE, overrun set, completion pulse.
- Wrap and reset:
  - 65536 handshakes -> counter reads 0.
  - Assert `rst_i` while PENDING -> `doorbell_irq_o` drops without a clock edge; all registers read 0 afterwards.
